// File: rtl/uart_tx_mmap.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_tx_mmap
//  Purpose  : Memory-mapped UART transmitter. Bytes written to TXDATA enter a
//             small FIFO. A bit-serial FSM sends each byte as a start bit,
//             eight data bits (LSB first), an optional even-parity bit and a
//             stop bit, each held for DIVISOR clock cycles.
//  Ports    : clk   - system clock, all state changes on the rising edge
//             reset - synchronous, active-high reset
//             re    - bus read strobe (reads have no side effects)
//             rd    - bus read data, combinational from addr
//             we    - bus write strobe
//             wd    - bus write data
//             addr  - word address, only addr[3:2] decoded
//             tx    - serial output, idle high
//  Register map (addr[3:2]):
//             0 TXDATA  : write pushes wd[7:0], reads 0
//             1 STATUS  : {parity_en, overflow, busy, empty, full}, write clears overflow
//             2 DIVISOR : clk cycles per bit in [15:0], 0 behaves as 1
//             3 reserved: reads 0, writes ignored
//  Options  : define UART_TX_PARITY_EN to insert an even-parity bit
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_mmap #(
    parameter int          DEPTH     = 4,
    parameter logic [15:0] DIV_RESET = 16'd868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        re,
    output logic [31:0] rd,
    input  logic        we,
    input  logic [31:0] wd,
    input  logic [31:2] addr,
    output logic        tx
);

    localparam int         AW           = $clog2(DEPTH);
    localparam logic [1:0] C_REG_TXDATA = 2'd0;
    localparam logic [1:0] C_REG_STATUS = 2'd1;
    localparam logic [1:0] C_REG_DIV    = 2'd2;

`ifdef UART_TX_PARITY_EN
    localparam logic       C_PARITY_EN  = 1'b1;
`else
    localparam logic       C_PARITY_EN  = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        , S_PARITY = 3'd4
`endif
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t         state_q,    state_d;
    logic           tx_q,       tx_d;
    logic [7:0]     shift_q,    shift_d;
    logic [15:0]    cnt_q,      cnt_d;      // cycles left in current bit
    logic [15:0]    reload_q,   reload_d;   // divisor latched for this frame
    logic [2:0]     bit_idx_q,  bit_idx_d;
    logic [15:0]    div_q,      div_d;
    logic           ovf_q,      ovf_d;
    logic [AW:0]    wr_ptr_q,   wr_ptr_d;
    logic [AW:0]    rd_ptr_q,   rd_ptr_d;
    logic [7:0]     mem_q [DEPTH];
`ifdef UART_TX_PARITY_EN
    logic           parity_q,   parity_d;
`endif

    // ------------------------------------------------------------------------
    // Decode and FIFO flags
    // ------------------------------------------------------------------------
    logic [1:0]  w_sel;
    logic        w_full;
    logic        w_empty;
    logic        w_txdata_wr;
    logic        w_push;
    logic        w_pop;
    logic        w_busy;
    logic [15:0] w_div_eff;
    logic [7:0]  w_head;
    logic        w_unused;

    assign w_sel       = addr[3:2];
    // The extra pointer MSB separates "wrapped once" (full) from "equal" (empty).
    assign w_full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_empty     = (wr_ptr_q == rd_ptr_q);
    assign w_txdata_wr = we && (w_sel == C_REG_TXDATA);
    // Fullness is judged before any same-cycle pop, so a push into a full FIFO
    // is always dropped.
    assign w_push      = w_txdata_wr && !w_full;
    assign w_pop       = (state_q == S_IDLE) && !w_empty;
    assign w_busy      = (state_q != S_IDLE);
    assign w_div_eff   = (div_q == 16'd0) ? 16'd1 : div_q;
    assign w_head      = mem_q[rd_ptr_q[AW-1:0]];

    // Bus inputs that carry no information for this block.
    assign w_unused    = ^{re, addr[31:4], wd[31:16]};

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        reload_d  = reload_q;
        bit_idx_d = bit_idx_q;
        div_d     = div_q;
        ovf_d     = ovf_q;
        wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, w_push};
        rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, w_pop};
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        // Register writes
        if (we && (w_sel == C_REG_STATUS)) begin
            ovf_d = 1'b0;
        end else if (w_txdata_wr && w_full) begin
            ovf_d = 1'b1;
        end
        if (we && (w_sel == C_REG_DIV)) begin
            div_d = wd[15:0];
        end

        // Transmit FSM. tx_d is the level for the next cycle, so every
        // transition also sets the line level of the state being entered.
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (w_pop) begin
                    shift_d   = w_head;
                    reload_d  = w_div_eff;
                    cnt_d     = w_div_eff - 16'd1;
                    bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^w_head;
`endif
                    tx_d      = 1'b0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (cnt_q == 16'd0) begin
                    cnt_d   = reload_q - 16'd1;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == 16'd0) begin
                    cnt_d = reload_q - 16'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == 16'd0) begin
                    cnt_d   = reload_q - 16'd1;
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`endif
            S_STOP: begin
                // Returning to IDLE costs one high cycle before the next pop.
                if (cnt_q == 16'd0) begin
                    tx_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            tx_q      <= 1'b1;
            shift_q   <= 8'd0;
            cnt_q     <= 16'd0;
            reload_q  <= 16'd0;
            bit_idx_q <= 3'd0;
            div_q     <= DIV_RESET;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            reload_q  <= reload_d;
            bit_idx_q <= bit_idx_d;
            div_q     <= div_d;
            ovf_q     <= ovf_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // FIFO storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wd[7:0];
        end
    end

    // ------------------------------------------------------------------------
    // Read mux and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        rd = 32'd0;
        case (w_sel)
            C_REG_STATUS: rd = {27'd0, C_PARITY_EN, ovf_q, w_busy, w_empty, w_full};
            C_REG_DIV:    rd = {16'd0, div_q};
            default:      rd = 32'd0;
        endcase
    end

    assign tx = tx_q;

endmodule
`default_nettype wire

// File: doc/uart_tx_mmap.md
UART_TX_MMAP -- requirements
Module: uart_tx_mmap

Interface
REQ-001 Parameter DEPTH, default 4, TX FIFO depth in bytes (power of two, >= 2).
REQ-002 Parameter DIV_RESET, default 16'd868, reset value of the DIVISOR register in clk cycles per bit.
REQ-003 Port clk  input  1  system clock; all state updates on rising edge.
REQ-004 Port reset  input  1  reset, synchronous, active-high.
REQ-005 Port re  input  1  bus read strobe (no side effects; rd is valid regardless).
REQ-006 Port rd  output  32  bus read data, combinational from addr.
REQ-007 Port we  input  1  bus write strobe, sampled on clk edge.
REQ-008 Port wd  input  32  bus write data.
REQ-009 Port addr  input  [31:2]  word address; only addr[3:2] decoded, higher bits ignored.
REQ-010 Port tx  output  1  serial line, idle high.

Function
REQ-011 Register map by addr[3:2]: 0 TXDATA, 1 STATUS, 2 DIVISOR, 3 reserved (read 0, write ignored).
REQ-012 TXDATA write: wd[7:0] pushed into FIFO if not full; TXDATA reads 0.
REQ-013 STATUS read: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky); bits 31:4 zero.
REQ-014 STATUS write (any data) clears overflow; write to TXDATA while full drops byte and sets overflow.
REQ-015 Push while full is dropped even if a pop occurs in the same cycle.
REQ-016 DIVISOR read returns {16'b0, div}; write loads wd[15:0]; value 0 treated as 1.
REQ-017 FSM states IDLE, START, DATA, STOP (PARITY when configured, see REQ-027).
REQ-018 IDLE: tx=1; if FIFO non-empty, pop head into shift register, latch div into bit counter reload, go START.
REQ-019 START: tx=0 for div cycles, then DATA with bit index 0.
REQ-020 DATA: tx=shift[0], LSB first, each bit div cycles; after bit 7 go STOP (or PARITY).
REQ-021 STOP: tx=1 for div cycles, then IDLE; next byte may pop on the first IDLE cycle (1 idle cycle between frames).
REQ-022 Latency: write to TXDATA with FIFO empty and FSM IDLE at edge N -> pop at edge N+1 -> tx low from edge N+1 onward.
REQ-023 DIVISOR writes during a frame do not affect it; the new value applies from the next pop.
REQ-024 FIFO pointers wrap modulo DEPTH; full/empty distinguished by extra pointer bit; occupancy never exceeds DEPTH.
REQ-025 Simultaneous push and pop with FIFO neither full nor empty: both take effect, occupancy unchanged.

Reset
REQ-026 On reset: FSM IDLE, tx=1, FIFO empty, overflow=0, div=DIV_RESET, shift register and counters 0; a frame in progress is aborted, tx returns high on the cycle after the reset edge.

Configuration
REQ-027 Macro UART_TX_PARITY_EN: when defined, PARITY state is inserted between DATA and STOP, driving even parity (XOR of the 8 data bits) for div cycles, and STATUS bit4 reads 1; when undefined, no PARITY state, 10-bit frames, STATUS bit4 reads 0.

Verification
REQ-028 Reset, then read addr 1 and addr 2 -> STATUS=0x2, DIVISOR=868, tx=1.
REQ-029 DIVISOR=4, write 0x55 to TXDATA -> tx sequence 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles (40 cycles), then idle; STATUS bit2 is 1 during the frame.
REQ-030 DIVISOR=2, DEPTH=4, write 6 bytes back-to-back while FSM busy -> first byte popped, next 4 queued, 6th dropped, STATUS=0xD (full, busy, overflow); STATUS write then clears bit3.
REQ-031 DIVISOR=3, write 0xA5 and 0x3C, change DIVISOR to 1 mid-frame -> first frame keeps 3 cycles/bit, second uses 1 cycle/bit, exactly 1 idle-high cycle between frames.
REQ-032 Assert reset during DATA of byte 0xFF with 2 bytes queued -> tx=1 after reset edge, STATUS=0x2, no further frame output.
REQ-033 With UART_TX_PARITY_EN, DIVISOR=1, write 0x07 -> tx 0,1,1,1,0,0,0,0,0,1(parity),1(stop); without it, the same write -> 10-bit frame ending 0,1(stop).
